// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: datapath widths, the access FSM
// state type and the packed width of the MEM/WB pipeline register.
`ifndef MEM_STAGE_PKG_MACROS
`define MEM_STAGE_PKG_MACROS
`define WORD     32
`define REG_SIZE 5
`endif

package mem_stage_pkg;

    // Data-memory access sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } memstate_t;

    // MEM/WB layout: readData, ALUResult, pc, writeReg, then four control bits.
    function automatic int memwb_size(input int word, input int reg_size);
        return 3 * word + reg_size + 4;
    endfunction

    localparam int MEMWB_SIZE = memwb_size(`WORD, `REG_SIZE);

endpackage

// File: rtl/flopr_async.sv
// Enable-free pipeline register with asynchronous active-high clear.
module flopr_async #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear to zero on reset, otherwise load every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: drives a valid/ready data-memory port with variable latency,
// stalls the front of the pipeline while an access is outstanding, resolves
// the branch decision and owns the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WORD     = `WORD,
    parameter int REG_SIZE = `REG_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD-1:0]     writeDataM,
    input  logic [WORD-1:0]     ALUResultM,
    input  logic [WORD-1:0]     pcM,
    input  logic [WORD-1:0]     pcALUM,
    input  logic [REG_SIZE-1:0] writeRegM,
    input  logic                regWriteM,
    input  logic                memWriteM,
    input  logic                mem2regM,
    input  logic                zeroM,
    input  logic                branchM,
    input  logic                finishM,
    input  logic                validM,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic                dmem_we,
    output logic [WORD-1:0]     dmem_addr,
    output logic [WORD-1:0]     dmem_wdata,
    input  logic                dmem_resp_valid,
    input  logic [WORD-1:0]     dmem_rdata,
    output logic                stallM,
    output logic                pcSrcM,
    output logic [WORD-1:0]     pcBranchM,
    output logic                misalignM,
    output logic [WORD-1:0]     readDataW,
    output logic [WORD-1:0]     ALUResultW,
    output logic [WORD-1:0]     pcW,
    output logic [REG_SIZE-1:0] writeRegW,
    output logic                regWriteW,
    output logic                mem2regW,
    output logic                finishW,
    output logic                validW
);

    localparam int MW = memwb_size(WORD, REG_SIZE);

    memstate_t state_q, state_d;

    logic          is_mem;
    logic          is_store;
    logic          is_load;
    logic          memop;
    logic [MW-1:0] memwb_d, memwb_q;
    logic [WORD-1:0] read_data_d;
    logic            reg_write_d;

    // A write flag wins over mem2reg, so an instruction is never both.
    assign is_mem    = validM & (memWriteM | mem2regM);
    assign is_store  = memWriteM;
    assign is_load   = mem2regM & ~memWriteM;
    assign misalignM = is_mem & (ALUResultM[1:0] != 2'b00);
    assign memop     = is_mem & ~misalignM;

    // Request payload comes straight from EX/MEM, which is frozen while stalled.
    assign dmem_we    = memWriteM;
    assign dmem_addr  = ALUResultM;
    assign dmem_wdata = writeDataM;

    // Branch resolution is purely combinational and independent of stalls.
    assign pcSrcM    = validM & branchM & zeroM;
    assign pcBranchM = pcALUM;

    // Access sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request valid and stall generation.
    always_comb begin
        state_d        = state_q;
        dmem_req_valid = 1'b0;
        stallM         = 1'b0;
        unique case (state_q)
            IDLE, REQ: begin
                if (memop) begin
                    dmem_req_valid = 1'b1;
                    if (dmem_req_ready) begin
                        // Stores finish on acceptance; loads wait for data.
                        if (is_store) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RESP;
                            stallM  = 1'b1;
                        end
                    end else begin
                        state_d = REQ;
                        stallM  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (dmem_resp_valid) begin
                    state_d = IDLE;
                end else begin
                    stallM = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // MEM/WB next value: bubble while stalled, otherwise retire the M instruction.
    always_comb begin
        read_data_d = (memop & is_load) ? dmem_rdata : '0;
        reg_write_d = regWriteM & validM & ~misalignM;
        if (stallM) begin
            memwb_d = {memwb_q[MW-1:4], 1'b0, memwb_q[2], 2'b00};
        end else begin
            memwb_d = {read_data_d, ALUResultM, pcM, writeRegM,
                       reg_write_d, mem2regM, finishM, validM};
        end
    end

    flopr_async #(.WIDTH(MW)) u_memwb (
        .clk   (clk),
        .reset (reset),
        .d     (memwb_d),
        .q     (memwb_q)
    );

    assign {readDataW, ALUResultW, pcW, writeRegW,
            regWriteW, mem2regW, finishW, validW} = memwb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instruction streams against a word-addressed memory model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] writeDataM, ALUResultM, pcM, pcALUM;
    logic [4:0]  writeRegM;
    logic        regWriteM, memWriteM, mem2regM, zeroM, branchM, finishM, validM;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_rdata;
    logic        stallM, pcSrcM, misalignM;
    logic [31:0] pcBranchM, readDataW, ALUResultW, pcW;
    logic [4:0]  writeRegW;
    logic        regWriteW, mem2regW, finishW, validW;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_model [logic [31:0]];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .writeDataM(writeDataM), .ALUResultM(ALUResultM), .pcM(pcM), .pcALUM(pcALUM),
        .writeRegM(writeRegM), .regWriteM(regWriteM), .memWriteM(memWriteM),
        .mem2regM(mem2regM), .zeroM(zeroM), .branchM(branchM), .finishM(finishM),
        .validM(validM),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
        .stallM(stallM), .pcSrcM(pcSrcM), .pcBranchM(pcBranchM), .misalignM(misalignM),
        .readDataW(readDataW), .ALUResultW(ALUResultW), .pcW(pcW), .writeRegW(writeRegW),
        .regWriteW(regWriteW), .mem2regW(mem2regW), .finishW(finishW), .validW(validW)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // After an edge on which the stage was stalled, W must hold a bubble.
    task automatic chk_bubble();
        chk("bubble_validW", {31'b0, validW}, 32'd0);
        chk("bubble_regWriteW", {31'b0, regWriteW}, 32'd0);
        chk("bubble_finishW", {31'b0, finishW}, 32'd0);
    endtask

    // One instruction through M. Called just after a posedge; returns just
    // after the posedge on which the instruction retires into W.
    // n = cycles with ready low before acceptance, m = cycles from acceptance
    // to load response (m >= 1).
    task automatic run(input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [31:0] pcalu,
                       input logic [4:0] rd, input logic rw, input logic mw,
                       input logic m2r, input logic z, input logic br,
                       input logic fin, input logic v, input int n, input int m);
        logic mis, memop, ld, exp_pcsrc;
        logic [31:0] exp_rd;
        mis       = v & (mw | m2r) & (alu[1:0] != 2'b00);
        memop     = v & (mw | m2r) & ~mis;
        ld        = m2r & ~mw;
        exp_pcsrc = v & br & z;
        exp_rd    = 32'd0;
        ALUResultM = alu; writeDataM = wd; pcM = pc; pcALUM = pcalu; writeRegM = rd;
        regWriteM = rw; memWriteM = mw; mem2regM = m2r; zeroM = z; branchM = br;
        finishM = fin; validM = v;
        if (!memop) begin
            dmem_req_ready  = 1'($urandom);
            dmem_resp_valid = 1'($urandom);
            dmem_rdata      = $urandom;
            @(negedge clk);
            chk("nomem_stallM", {31'b0, stallM}, 32'd0);
            chk("nomem_req_valid", {31'b0, dmem_req_valid}, 32'd0);
            chk("misalignM", {31'b0, misalignM}, {31'b0, mis});
            chk("pcSrcM", {31'b0, pcSrcM}, {31'b0, exp_pcsrc});
            chk("pcBranchM", pcBranchM, pcalu);
            @(posedge clk); #1;
        end else begin
            for (int i = 0; i < n; i++) begin
                dmem_req_ready  = 1'b0;
                dmem_resp_valid = 1'($urandom);
                dmem_rdata      = $urandom;
                @(negedge clk);
                chk("wait_req_valid", {31'b0, dmem_req_valid}, 32'd1);
                chk("wait_stallM", {31'b0, stallM}, 32'd1);
                chk("wait_addr", dmem_addr, alu);
                chk("wait_we", {31'b0, dmem_we}, {31'b0, mw});
                chk("pcSrcM", {31'b0, pcSrcM}, {31'b0, exp_pcsrc});
                @(posedge clk); #1;
                chk_bubble();
            end
            dmem_req_ready  = 1'b1;
            dmem_resp_valid = 1'($urandom);
            dmem_rdata      = $urandom;
            @(negedge clk);
            chk("acc_req_valid", {31'b0, dmem_req_valid}, 32'd1);
            chk("acc_stallM", {31'b0, stallM}, {31'b0, ld});
            chk("acc_addr", dmem_addr, alu);
            chk("acc_we", {31'b0, dmem_we}, {31'b0, mw});
            if (mw) chk("acc_wdata", dmem_wdata, wd);
            chk("acc_misalignM", {31'b0, misalignM}, 32'd0);
            @(posedge clk);
            if (mw) mem_model[alu] = wd;
            #1;
            if (ld) begin
                chk_bubble();
                if (!mem_model.exists(alu)) mem_model[alu] = $urandom;
                exp_rd = mem_model[alu];
                for (int j = 0; j < m - 1; j++) begin
                    dmem_req_ready  = 1'($urandom);
                    dmem_resp_valid = 1'b0;
                    dmem_rdata      = $urandom;
                    @(negedge clk);
                    chk("resp_wait_req_valid", {31'b0, dmem_req_valid}, 32'd0);
                    chk("resp_wait_stallM", {31'b0, stallM}, 32'd1);
                    @(posedge clk); #1;
                    chk_bubble();
                end
                dmem_req_ready  = 1'($urandom);
                dmem_resp_valid = 1'b1;
                dmem_rdata      = exp_rd;
                @(negedge clk);
                chk("resp_req_valid", {31'b0, dmem_req_valid}, 32'd0);
                chk("resp_stallM", {31'b0, stallM}, 32'd0);
                @(posedge clk); #1;
            end
        end
        dmem_resp_valid = 1'b0;
        chk("W_validW", {31'b0, validW}, {31'b0, v});
        chk("W_regWriteW", {31'b0, regWriteW}, {31'b0, rw & v & ~mis});
        chk("W_mem2regW", {31'b0, mem2regW}, {31'b0, m2r});
        chk("W_finishW", {31'b0, finishW}, {31'b0, fin});
        chk("W_writeRegW", {27'b0, writeRegW}, {27'b0, rd});
        chk("W_ALUResultW", ALUResultW, alu);
        chk("W_pcW", pcW, pc);
        chk("W_readDataW", readDataW, exp_rd);
        $display("instr pc=%h alu=%h we=%0b ld=%0b v=%0b mis=%0b n=%0d m=%0d readDataW=%h",
                 pc, alu, mw, m2r, v, mis, n, m, readDataW);
    endtask

    initial begin
        logic [31:0] a;
        int kind;
        reset = 1'b1;
        writeDataM = '0; ALUResultM = '0; pcM = '0; pcALUM = '0; writeRegM = '0;
        regWriteM = 0; memWriteM = 0; mem2regM = 0; zeroM = 0; branchM = 0;
        finishM = 0; validM = 0;
        dmem_req_ready = 0; dmem_resp_valid = 0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_validW", {31'b0, validW}, 32'd0);
        chk("rst_readDataW", readDataW, 32'd0);
        chk("rst_pcW", pcW, 32'd0);
        chk("rst_stallM", {31'b0, stallM}, 32'd0);
        reset = 1'b0;

        // Directed scenarios.
        run(32'h100, 32'hDEADBEEF, 32'h10, 32'h0, 5'd0, 0, 1, 0, 0, 0, 0, 1, 0, 1);
        mem_model[32'h104] = 32'h12345678;
        run(32'h104, 32'h0, 32'h14, 32'h0, 5'd3, 1, 0, 1, 0, 0, 0, 1, 0, 1);
        run(32'h104, 32'h0, 32'h18, 32'h0, 5'd4, 1, 0, 1, 0, 0, 0, 1, 3, 2);
        run(32'h55, 32'h0, 32'h1C, 32'h0, 5'd5, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        run(32'h0, 32'h0, 32'h20, 32'h40, 5'd0, 0, 0, 0, 1, 1, 0, 1, 0, 1);
        run(32'h102, 32'h0, 32'h24, 32'h0, 5'd6, 1, 0, 1, 0, 0, 0, 1, 0, 1);
        run(32'h108, 32'h0, 32'h28, 32'h0, 5'd7, 1, 0, 1, 0, 0, 1, 0, 0, 1);

        // Randomized instruction stream.
        for (int k = 0; k < 250; k++) begin
            kind = $urandom_range(0, 3);
            a = {22'b0, 8'($urandom), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            run(a, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                kind == 2, kind == 1, 1'($urandom), kind == 3, 1'($urandom),
                $urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(1, 3));
        end

        // Known nonzero W contents before the mid-RESP reset.
        mem_model[32'h200] = 32'hCAFEF00D;
        run(32'h200, 32'h0, 32'h30, 32'h0, 5'd8, 1, 0, 1, 0, 0, 0, 1, 0, 1);
        // Issue a load and get it accepted, leaving the FSM waiting for data.
        ALUResultM = 32'h204; pcM = 32'h34; mem2regM = 1; memWriteM = 0; regWriteM = 1;
        validM = 1; branchM = 0; finishM = 0;
        dmem_req_ready = 1'b1; dmem_resp_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_stallM", {31'b0, stallM}, 32'd1);
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_validW", {31'b0, validW}, 32'd0);
        chk("async_rst_readDataW", readDataW, 32'd0);
        chk("async_rst_regWriteW", {31'b0, regWriteW}, 32'd0);
        chk("async_rst_req_valid", {31'b0, dmem_req_valid}, 32'd1);
        chk("async_rst_stallM", {31'b0, stallM}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("post_rst_validW", {31'b0, validW}, 32'd0);
        mem_model[32'h204] = 32'h0BADF00D;
        run(32'h204, 32'h0, 32'h34, 32'h0, 5'd9, 1, 0, 1, 0, 0, 0, 1, 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
